tl_async_queue_sink: RTL

//  Receive-side half of a TileLink asynchronous crossing. It lives in the consumer

---
 rtl/tl_async_queue_sink_if.sv | 30 +++
 rtl/tl_async_queue_sink.sv | 105 ++++++++++
 2 files changed

// File: rtl/tl_async_queue_sink_if.sv
// Bundle between the async-crossing sink, its source half and the dequeue consumer.
interface tl_async_queue_sink_if #(
  parameter int unsigned WIDTH = 55,
  parameter int unsigned DEPTH = 1
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [DEPTH*WIDTH-1:0] async_mem;
  logic [PW-1:0]          async_widx;
  logic                   async_safe_widx_valid;
  logic                   async_safe_source_reset_n;
  logic [PW-1:0]          async_ridx;
  logic                   async_safe_ridx_valid;
  logic                   async_safe_sink_reset_n;
  logic                   deq_valid;
  logic [WIDTH-1:0]       deq_bits;
  logic                   deq_ready;

  // Source side plus consumer: drives memory, write pointer and ready
  modport master (
    output async_mem, async_widx, async_safe_widx_valid, async_safe_source_reset_n, deq_ready,
    input  async_ridx, async_safe_ridx_valid, async_safe_sink_reset_n, deq_valid, deq_bits
  );

  // Sink side: owns the read pointer and the dequeue register
  modport slave (
    input  async_mem, async_widx, async_safe_widx_valid, async_safe_source_reset_n, deq_ready,
    output async_ridx, async_safe_ridx_valid, async_safe_sink_reset_n, deq_valid, deq_bits
  );
endinterface

// File: rtl/tl_async_queue_sink.sv
// Consumer-domain half of a TileLink async queue: synchronises the gray write
// pointer, reads source-owned entries into a registered dequeue stage and returns
// a gray read pointer plus reset handshake to the source.
module tl_async_queue_sink #(
  parameter int unsigned WIDTH = 55,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned SYNC  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_async_queue_sink_if.slave  io
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SYNC-1:0]  src_sync_q, src_sync_d;
  logic [SYNC-1:0]  wv_sync_q, wv_sync_d;
  logic [PW-1:0]    widx_sync_q [SYNC];
  logic [PW-1:0]    widx_sync_d [SYNC];
  logic [PW-1:0]    ridx_bin_q, ridx_bin_d;
  logic [PW-1:0]    ridx_gray_q, ridx_gray_d;
  logic             ridx_valid_q, ridx_valid_d;
  logic             deq_valid_q, deq_valid_d;
  logic [WIDTH-1:0] deq_bits_q, deq_bits_d;

  logic             src_ok, wv_ok, avail, load;
  logic [PW-1:0]    widx_s;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] x);
    return x ^ (x >> 1);
  endfunction

  assign src_ok = src_sync_q[SYNC-1];
  assign wv_ok  = wv_sync_q[SYNC-1];
  assign widx_s = widx_sync_q[SYNC-1];
  assign avail  = src_ok & wv_ok & (widx_s != gray(ridx_bin_q));
  assign load   = avail & (~deq_valid_q | io.deq_ready);

  // Entry select; a single-entry memory always reads slot 0
  always_comb begin
    rd_idx  = (DEPTH == 1) ? '0 : ridx_bin_q[AW-1:0];
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_idx == AW'(i)) rd_data = io.async_mem[i*WIDTH +: WIDTH];
    end
  end

  // Next state: synchronisers, read pointer and dequeue register
  always_comb begin
    src_sync_d     = {src_sync_q[SYNC-2:0], io.async_safe_source_reset_n};
    wv_sync_d      = {wv_sync_q[SYNC-2:0], io.async_safe_widx_valid};
    widx_sync_d[0] = io.async_widx;
    for (int unsigned i = 1; i < SYNC; i++) widx_sync_d[i] = widx_sync_q[i-1];
    ridx_valid_d   = src_ok;
    ridx_bin_d     = ridx_bin_q;
    deq_valid_d    = deq_valid_q;
    deq_bits_d     = deq_bits_q;

    if (!src_ok) begin
      // Source in reset: drop any held beat and restart from pointer zero
      ridx_bin_d  = '0;
      deq_valid_d = 1'b0;
      for (int unsigned i = 0; i < SYNC; i++) widx_sync_d[i] = '0;
    end else if (load) begin
      deq_bits_d  = rd_data;
      ridx_bin_d  = ridx_bin_q + PW'(1);
      deq_valid_d = 1'b1;
    end else if (deq_valid_q && io.deq_ready) begin
      deq_valid_d = 1'b0;
    end

    ridx_gray_d = gray(ridx_bin_d);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      src_sync_q   <= '0;
      wv_sync_q    <= '0;
      for (int unsigned i = 0; i < SYNC; i++) widx_sync_q[i] <= '0;
      ridx_bin_q   <= '0;
      ridx_gray_q  <= '0;
      ridx_valid_q <= 1'b0;
      deq_valid_q  <= 1'b0;
      deq_bits_q   <= '0;
    end else begin
      src_sync_q   <= src_sync_d;
      wv_sync_q    <= wv_sync_d;
      widx_sync_q  <= widx_sync_d;
      ridx_bin_q   <= ridx_bin_d;
      ridx_gray_q  <= ridx_gray_d;
      ridx_valid_q <= ridx_valid_d;
      deq_valid_q  <= deq_valid_d;
      deq_bits_q   <= deq_bits_d;
    end
  end

  assign io.async_ridx              = ridx_gray_q;
  assign io.async_safe_ridx_valid   = ridx_valid_q;
  assign io.async_safe_sink_reset_n = ~reset;
  assign io.deq_valid               = deq_valid_q;
  assign io.deq_bits                = deq_bits_q;
endmodule
